// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive control slice.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RECEIVE,
    STOP_CHK,
    LOAD
  } rcv_state_t;

  localparam int RX_DATA_WIDTH = 8;

  // Idle serial line reads as all ones; the buffer powers up showing that pattern.
  localparam logic [63:0] RX_IDLE_DATA = '1;

endpackage

// File: rtl/rcv_pkt_ctrl_if.sv
// Bundles the receiver front-end and host handshake signals of rcv_pkt_ctrl.
interface rcv_pkt_ctrl_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  start_bit_detected;
    logic                  packet_done;
    logic                  stop_bit;
    logic [DATA_WIDTH-1:0] packet_data;
    logic                  data_read;
    logic                  sbc_clear;
    logic                  enable_timer;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  data_ready;
    logic                  overrun_error;
    logic                  framing_error;

    // master: the receive controller itself
    modport master (
        input  start_bit_detected,
        input  packet_done,
        input  stop_bit,
        input  packet_data,
        input  data_read,
        output sbc_clear,
        output enable_timer,
        output rx_data,
        output data_ready,
        output overrun_error,
        output framing_error
    );

    // slave: shift register, timer and host surrounding the controller
    modport slave (
        output start_bit_detected,
        output packet_done,
        output stop_bit,
        output packet_data,
        output data_read,
        input  sbc_clear,
        input  enable_timer,
        input  rx_data,
        input  data_ready,
        input  overrun_error,
        input  framing_error
    );

endinterface

// File: rtl/rx_data_buff.sv
// Host-visible receive buffer: holds the last good byte plus the ready/overrun handshake.
module rx_data_buff
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load_buffer,
    input  logic [DATA_WIDTH-1:0] packet_data,
    input  logic                  data_read,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  data_ready,
    output logic                  overrun_error
);

    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  data_ready_q, data_ready_d;
    logic                  overrun_error_q, overrun_error_d;

    always_comb begin
        rx_data_d       = rx_data_q;
        data_ready_d    = data_ready_q;
        overrun_error_d = overrun_error_q;
        if (load_buffer) begin
            rx_data_d    = packet_data;
            data_ready_d = 1'b1;
            // A read in the load cycle consumes the old byte, so nothing was lost.
            if (data_read) begin
                overrun_error_d = 1'b0;
            end else if (data_ready_q) begin
                overrun_error_d = 1'b1;
            end
        end else if (data_read && data_ready_q) begin
            data_ready_d    = 1'b0;
            overrun_error_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data_q       <= RX_IDLE_DATA[DATA_WIDTH-1:0];
            data_ready_q    <= 1'b0;
            overrun_error_q <= 1'b0;
        end else begin
            rx_data_q       <= rx_data_d;
            data_ready_q    <= data_ready_d;
            overrun_error_q <= overrun_error_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = data_ready_q;
    assign overrun_error = overrun_error_q;

endmodule

// File: rtl/rcv_pkt_ctrl.sv
// UART receive packet sequencer: start -> clear -> receive -> stop check -> load or framing error.
module rcv_pkt_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = RX_DATA_WIDTH
) (
    input logic            clk,
    input logic            n_rst,
    rcv_pkt_ctrl_if.master bus
);

    rcv_state_t state_q, state_d;
    logic       sbc_clear_q, sbc_clear_d;
    logic       enable_timer_q, enable_timer_d;
    logic       load_buffer_q, load_buffer_d;
    logic       framing_error_q, framing_error_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start_bit_detected) state_d = START;
            START:    state_d = RECEIVE;
            RECEIVE:  if (bus.packet_done) state_d = STOP_CHK;
            STOP_CHK: state_d = bus.stop_bit ? LOAD : IDLE;
            LOAD:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet still
    // line up with the cycle the FSM spends in each state.
    always_comb begin
        sbc_clear_d     = (state_d == START);
        enable_timer_d  = (state_d == RECEIVE);
        load_buffer_d   = (state_d == LOAD);
        framing_error_d = framing_error_q;
        if (state_d == START) begin
            framing_error_d = 1'b0;
        end else if ((state_q == STOP_CHK) && !bus.stop_bit) begin
            framing_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            sbc_clear_q     <= 1'b0;
            enable_timer_q  <= 1'b0;
            load_buffer_q   <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            sbc_clear_q     <= sbc_clear_d;
            enable_timer_q  <= enable_timer_d;
            load_buffer_q   <= load_buffer_d;
            framing_error_q <= framing_error_d;
        end
    end

    assign bus.sbc_clear     = sbc_clear_q;
    assign bus.enable_timer  = enable_timer_q;
    assign bus.framing_error = framing_error_q;

    rx_data_buff #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rx_data_buff (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_buffer  (load_buffer_q),
        .packet_data  (bus.packet_data),
        .data_read    (bus.data_read),
        .rx_data      (bus.rx_data),
        .data_ready   (bus.data_ready),
        .overrun_error(bus.overrun_error)
    );

endmodule

// File: tb/tb_rcv_pkt_ctrl.sv
// Randomized scoreboard bench for rcv_pkt_ctrl with a packet-level reference model.
module tb_rcv_pkt_ctrl;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    rcv_pkt_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    rcv_pkt_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          ready;
        logic          ovr;
        logic          frm;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: host-visible state after each whole packet / read
    logic [DW-1:0] m_data;
    logic          m_ready, m_ovr, m_frm;
    logic          mon_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_data  = 8'hFF;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_frm   = 1'b0;
    endtask

    task automatic do_read();
        bus.data_read = 1'b1;
        tick();
        bus.data_read = 1'b0;
        if (m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
        check("read_ready", bus.data_ready, m_ready);
        check("read_ovr", bus.overrun_error, m_ovr);
        check("read_data", bus.rx_data, m_data);
    endtask

    task automatic send_packet(input logic [DW-1:0] d, input logic stop, input logic rd_in_load,
                               input int rx_cycles, input logic ghost);
        exp_t e;
        bus.start_bit_detected = 1'b1;
        tick();
        bus.start_bit_detected = 1'b0;
        m_frm = 1'b0;
        check("sbc_clear_n1", bus.sbc_clear, 1);
        check("timer_n1", bus.enable_timer, 0);
        check("framing_clr", bus.framing_error, m_frm);
        tick();
        check("sbc_clear_n2", bus.sbc_clear, 0);
        check("timer_n2", bus.enable_timer, 1);
        for (int i = 0; i < rx_cycles; i++) begin
            if (ghost && i == 0) begin
                bus.start_bit_detected = 1'b1;
                tick();
                bus.start_bit_detected = 1'b0;
                check("ghost_sbc", bus.sbc_clear, 0);
                check("ghost_timer", bus.enable_timer, 1);
            end else begin
                tick();
            end
        end
        bus.packet_data = d;
        bus.stop_bit    = stop;
        bus.packet_done = 1'b1;
        if (!stop) begin
            m_frm = 1'b1;
        end else begin
            // Overrun means an unread byte got overwritten; a same-cycle read rescues it.
            if (rd_in_load) m_ovr = 1'b0;
            else if (m_ready) m_ovr = 1'b1;
            m_ready = 1'b1;
            m_data  = d;
        end
        e.data  = m_data;
        e.ready = m_ready;
        e.ovr   = m_ovr;
        e.frm   = m_frm;
        sb_q.push_back(e);
        tick();
        bus.packet_done = 1'b0;
        check("timer_stopchk", bus.enable_timer, 0);
        tick();
        if (stop && rd_in_load) bus.data_read = 1'b1;
        tick();
        bus.data_read = 1'b0;
    endtask

    // Monitor: a falling enable_timer marks packet end; results are visible two cycles later.
    initial begin
        exp_t e;
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (n_rst !== 1'b1) begin
                mon_prev = 1'b0;
            end else if (mon_prev && !bus.enable_timer) begin
                @(negedge clk);
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("mon_rx_data", bus.rx_data, e.data);
                    check("mon_data_ready", bus.data_ready, e.ready);
                    check("mon_overrun", bus.overrun_error, e.ovr);
                    check("mon_framing", bus.framing_error, e.frm);
                end
                mon_prev = bus.enable_timer;
            end else begin
                mon_prev = bus.enable_timer;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_bit_detected = 1'b0;
        bus.packet_done        = 1'b0;
        bus.stop_bit           = 1'b1;
        bus.packet_data        = '0;
        bus.data_read          = 1'b0;
        n_rst = 1'b1;
        #1 n_rst = 1'b0;
        #2;
        model_reset();
        check("rst_sbc_clear", bus.sbc_clear, 0);
        check("rst_timer", bus.enable_timer, 0);
        check("rst_rx_data", bus.rx_data, 8'hFF);
        check("rst_ready", bus.data_ready, 0);
        check("rst_overrun", bus.overrun_error, 0);
        check("rst_framing", bus.framing_error, 0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // Directed: clean, framing, overrun, read-clear, collision, ignored start
        send_packet(8'hA5, 1'b1, 1'b0, 4, 1'b0);
        do_read();
        send_packet(8'h3C, 1'b0, 1'b0, 3, 1'b0);
        send_packet(8'h11, 1'b1, 1'b0, 5, 1'b0);
        send_packet(8'h22, 1'b1, 1'b0, 2, 1'b0);
        do_read();
        send_packet(8'h33, 1'b1, 1'b0, 3, 1'b0);
        send_packet(8'h44, 1'b1, 1'b1, 3, 1'b0);
        send_packet(8'h55, 1'b1, 1'b0, 6, 1'b1);

        for (int k = 0; k < 40; k++) begin
            logic [DW-1:0] d;
            logic          stop, rdl, ghost;
            int            cyc;
            d     = DW'($urandom);
            stop  = ($urandom_range(0, 3) != 0);
            rdl   = ($urandom_range(0, 2) == 0);
            ghost = ($urandom_range(0, 3) == 0);
            cyc   = $urandom_range(2, 9);
            if ($urandom_range(0, 2) == 0) do_read();
            send_packet(d, stop, rdl, cyc, ghost);
        end

        // Reset in the middle of RECEIVE aborts the packet
        bus.start_bit_detected = 1'b1;
        tick();
        bus.start_bit_detected = 1'b0;
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        model_reset();
        check("mid_rst_timer", bus.enable_timer, 0);
        check("mid_rst_rx_data", bus.rx_data, m_data);
        check("mid_rst_ready", bus.data_ready, m_ready);
        check("mid_rst_overrun", bus.overrun_error, m_ovr);
        check("mid_rst_framing", bus.framing_error, m_frm);
        tick();
        n_rst = 1'b1;
        bus.packet_data = 8'h5A;
        bus.stop_bit    = 1'b1;
        bus.packet_done = 1'b1;
        tick();
        bus.packet_done = 1'b0;
        tick();
        tick();
        tick();
        check("post_rst_ready", bus.data_ready, 0);
        check("post_rst_rx_data", bus.rx_data, 8'hFF);
        check("post_rst_timer", bus.enable_timer, 0);
        check("post_rst_sbc", bus.sbc_clear, 0);

        tick();
        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
